barrel_shift_left_seq: RTL and testbench
========================================

// Module: barrel_shift_left_seq
// PURPOSE
//  Multi-cycle left barrel shifter: complements the combinational logical right shifter.
//  Accepts an operand, shift amount and mode over a valid/ready handshake.
//  Applies the log2(WIDTH) shift stages one per clock, from the largest stage to the smallest.
//  Presents the result with a valid/ready handshake and holds it under backpressure.
//  Sits between the datapath operand registers and the result writeback.
// PARAMETERS
//  WIDTH  8               operand width; power of 2, >= 2
//  SHW    $clog2(WIDTH)   shift-amount width = number of stages (derived; do not override)
// PORTS
//  clk        in   1      clock, rising edge
//  rst_n      in   1      asynchronous active-low reset
//  in         in   WIDTH  operand
//  ctrl       in   SHW    shift amount, 0..WIDTH-1
//  rot        in   1      1 = rotate left; 0 = logical left, zero fill
//  in_valid   in   1      operand/ctrl/rot valid
//  in_ready   out  1      block can accept; high only in IDLE (combinational from state)
//  out        out  WIDTH  shifted result
//  ovf        out  1      logical mode: OR of all bits shifted out; always 0 in rotate mode
//  out_valid  out  1      out/ovf valid
//  out_ready  in   1      consumer accepts result
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - state=IDLE, stage counter=0, out=0, ovf=0, out_valid=0, so in_ready=1.
//   - Internal data/ctrl/rot registers are cleared to 0.
//   - Reset mid-operation aborts the operation; no result is ever produced for it.
//  States: IDLE, SHIFT, DONE.
//  IDLE:
//   - On in_valid & in_ready: capture in, ctrl and rot; clear the ovf accumulator; stage k=SHW-1; go to SHIFT.
//  SHIFT (one edge per stage k = SHW-1 down to 0):
//   - If ctrl[k]=1: data <= data << 2^k.
//   - Rotate mode: the vacated low bits take the bits shifted out.
//   - Logical mode: the vacated low bits are 0, and ovf_acc |= OR of the 2^k bits shifted out.
//   - If ctrl[k]=0: data and ovf_acc are unchanged.
//   - After the k=0 edge: out<=data result, ovf<=ovf_acc (0 if rot), out_valid<=1; go to DONE.
//  DONE:
//   - out and ovf are stable while out_valid=1 and out_ready=0 (indefinite backpressure allowed).
//   - On out_valid & out_ready: out_valid<=0; go to IDLE.
//   - out and ovf keep their last value until the next result is loaded.
//  Latency and throughput:
//   - Handshake edge at t0; out_valid is high from edge t0+SHW (3 for WIDTH=8).
//   - Latency is constant, independent of ctrl, including ctrl=0.
//   - A new accept is earliest one cycle after the output handshake.
//   - Best-case throughput is 1 op per SHW+2 cycles.
//  Boundary conditions:
//   - in_valid while busy (SHIFT/DONE) is ignored; the inputs need not be held after accept.
//   - ctrl=0: out=in, ovf=0.
//   - ctrl=WIDTH-1, logical: out = {in[0], zeros}, ovf = |in[WIDTH-1:1].
//   - out_ready while out_valid=0 has no effect.
//   - All arithmetic is WIDTH bits; no result bit depends on X inputs after the capture edge.
// TESTING (WIDTH=8)
//  1. in=8'b1011_0011, ctrl=3, rot=0
//     -> out=8'b1001_1000, ovf=1, out_valid rises 3 edges after accept.
//  2. Same operand, rot=1 -> out=8'b1001_1101, ovf=0.
//  3. in=8'hA5, ctrl=0, both modes -> out=8'hA5, ovf=0, latency still 3.
//  4. ctrl=7, rot=0: in=8'h01 -> out=8'h80, ovf=0; in=8'h03 -> out=8'h80, ovf=1.
//  5. out_ready=0 for 5 cycles, in_valid pulsed with new data meanwhile
//     -> out/ovf stable, in_ready=0, new data not taken.
//     Then out_ready=1 -> IDLE, in_ready=1 next cycle, next op correct.
//  6. rst_n=0 asynchronously mid-SHIFT
//     -> out=0, ovf=0, out_valid=0, in_ready=1 without a clock edge.
//     After release, the next op completes normally.

Source files
------------

// File: rtl/barrel_shift_left_seq.sv
// Multi-cycle left barrel shifter (logical or rotate), one power-of-two stage per clock,
// largest stage first, with valid/ready handshakes on both the operand and result sides.
module barrel_shift_left_seq #(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in,
    input  logic [SHW-1:0]   ctrl,
    input  logic             rot,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out,
    output logic             ovf,
    output logic             out_valid,
    input  logic             out_ready
);

    // Handshake rule on both sides: a transfer happens on a rising edge where valid and
    // ready are both high; the producer holds its payload stable until that edge.

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] data_q;
    logic [SHW-1:0]   ctrl_q;
    logic             rot_q;
    logic             ovf_acc;
    logic [SHW-1:0]   k_q;

    logic [WIDTH-1:0] stage_data;
    logic             stage_ovf;
    logic [WIDTH-1:0] lost_bits;

    assign in_ready = (state_q == IDLE);

    // One stage of the shift network, selected by the current stage index k_q.
    always_comb begin
        stage_data = data_q;
        stage_ovf  = 1'b0;
        lost_bits  = '0;
        for (int s = 0; s < SHW; s++) begin
            if (k_q == SHW'(s) && ctrl_q[s]) begin
                lost_bits = data_q >> (WIDTH - (1 << s));
                if (rot_q) begin
                    stage_data = (data_q << (1 << s)) | lost_bits;
                end else begin
                    stage_data = data_q << (1 << s);
                    stage_ovf  = |lost_bits;
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = SHIFT;
            SHIFT:   if (k_q == '0) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q    <= '0;
            ctrl_q    <= '0;
            rot_q     <= 1'b0;
            ovf_acc   <= 1'b0;
            k_q       <= '0;
            out       <= '0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        data_q  <= in;
                        ctrl_q  <= ctrl;
                        rot_q   <= rot;
                        ovf_acc <= 1'b0;
                        k_q     <= SHW'(SHW - 1);
                    end
                end
                SHIFT: begin
                    data_q  <= stage_data;
                    ovf_acc <= ovf_acc | stage_ovf;
                    if (k_q == '0) begin
                        out       <= stage_data;
                        ovf       <= rot_q ? 1'b0 : (ovf_acc | stage_ovf);
                        out_valid <= 1'b1;
                    end else begin
                        k_q <= k_q - 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) out_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_barrel_shift_left_seq.sv
// Directed bench for barrel_shift_left_seq at WIDTH=8: results, overflow, latency,
// backpressure, busy-input rejection and asynchronous reset.
module tb_barrel_shift_left_seq;

    localparam int WIDTH = 8;
    localparam int SHW   = 3;

    logic             clk;
    logic             rst_n;
    logic [WIDTH-1:0] in;
    logic [SHW-1:0]   ctrl;
    logic             rot;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out;
    logic             ovf;
    logic             out_valid;
    logic             out_ready;

    int total = 0;
    int bad   = 0;

    barrel_shift_left_seq #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in        (in),
        .ctrl      (ctrl),
        .rot       (rot),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out       (out),
        .ovf       (ovf),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // driver: offer one operand, return result and edges from accept to out_valid (99 = timeout)
    task automatic run_op(input logic [7:0] a, input logic [2:0] c, input logic r,
                          output logic [7:0] res, output logic res_ovf, output int lat);
        int wait_cnt;
        in = a; ctrl = c; rot = r; in_valid = 1'b1;
        wait_cnt = 0;
        while (!in_ready && wait_cnt < 20) begin
            step();
            wait_cnt++;
        end
        step();
        in_valid = 1'b0;
        in = 8'($urandom_range(0, 255));
        ctrl = 3'($urandom_range(0, 7));
        rot = 1'($urandom_range(0, 1));
        lat = 0;
        while (!out_valid && lat < 20) begin
            step();
            lat++;
        end
        if (wait_cnt >= 20 || lat >= 20) lat = 99;
        res = out;
        res_ovf = ovf;
    endtask

    // driver: consume the pending result
    task automatic pop();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in = '0; ctrl = '0; rot = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        step(); step();
        total++;
        if (out !== 8'h00 || ovf !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset: out=%h ovf=%b out_valid=%b in_ready=%b required 00 0 0 1",
                     out, ovf, out_valid, in_ready);
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_logical();
        logic [7:0] r; logic o; int lat;
        run_op(8'b1011_0011, 3'd3, 1'b0, r, o, lat);
        total++;
        if (r !== 8'b1001_1000 || o !== 1'b1 || lat !== 3) begin
            bad++;
            $display("FAIL logical_b3_sh3: out=%h ovf=%b lat=%0d required 98 1 3", r, o, lat);
        end
        pop();
        run_op(8'h0F, 3'd4, 1'b0, r, o, lat);
        total++;
        if (r !== 8'hF0 || o !== 1'b0) begin
            bad++;
            $display("FAIL logical_0f_sh4: out=%h ovf=%b required f0 0", r, o);
        end
        pop();
        run_op(8'h80, 3'd1, 1'b0, r, o, lat);
        total++;
        if (r !== 8'h00 || o !== 1'b1) begin
            bad++;
            $display("FAIL logical_80_sh1: out=%h ovf=%b required 00 1", r, o);
        end
        pop();
    endtask

    task automatic test_rotate();
        logic [7:0] r; logic o; int lat;
        run_op(8'b1011_0011, 3'd3, 1'b1, r, o, lat);
        total++;
        if (r !== 8'b1001_1101 || o !== 1'b0 || lat !== 3) begin
            bad++;
            $display("FAIL rotate_b3_sh3: out=%h ovf=%b lat=%0d required 9d 0 3", r, o, lat);
        end
        pop();
        run_op(8'hC3, 3'd5, 1'b1, r, o, lat);
        total++;
        if (r !== 8'h78 || o !== 1'b0) begin
            bad++;
            $display("FAIL rotate_c3_sh5: out=%h ovf=%b required 78 0", r, o);
        end
        pop();
    endtask

    task automatic test_zero_shift();
        logic [7:0] r; logic o; int lat;
        for (int m = 0; m < 2; m++) begin
            run_op(8'hA5, 3'd0, 1'(m), r, o, lat);
            total++;
            if (r !== 8'hA5 || o !== 1'b0 || lat !== 3) begin
                bad++;
                $display("FAIL zero_shift_rot%0d: out=%h ovf=%b lat=%0d required a5 0 3", m, r, o, lat);
            end
            pop();
        end
    endtask

    task automatic test_max_shift();
        logic [7:0] r; logic o; int lat;
        run_op(8'h01, 3'd7, 1'b0, r, o, lat);
        total++;
        if (r !== 8'h80 || o !== 1'b0) begin
            bad++;
            $display("FAIL max_shift_01: out=%h ovf=%b required 80 0", r, o);
        end
        pop();
        run_op(8'h03, 3'd7, 1'b0, r, o, lat);
        total++;
        if (r !== 8'h80 || o !== 1'b1) begin
            bad++;
            $display("FAIL max_shift_03: out=%h ovf=%b required 80 1", r, o);
        end
        pop();
    endtask

    task automatic test_backpressure();
        logic [7:0] r; logic o; int lat;
        run_op(8'b1011_0011, 3'd3, 1'b0, r, o, lat);
        for (int i = 0; i < 5; i++) begin
            in = 8'hFF; ctrl = 3'd1; rot = 1'b1; in_valid = 1'b1;
            step();
            total++;
            if (out !== 8'h98 || ovf !== 1'b1 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
                bad++;
                $display("FAIL hold_%0d: out=%h ovf=%b out_valid=%b in_ready=%b required 98 1 1 0",
                         i, out, ovf, out_valid, in_ready);
            end
        end
        in_valid = 1'b0;
        pop();
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out !== 8'h98 || ovf !== 1'b1) begin
            bad++;
            $display("FAIL release: out_valid=%b in_ready=%b out=%h ovf=%b required 0 1 98 1",
                     out_valid, in_ready, out, ovf);
        end
        // nothing was captured during the stall, so no result appears
        for (int i = 0; i < 5; i++) step();
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL no_capture: out_valid=%b in_ready=%b required 0 1", out_valid, in_ready);
        end
        run_op(8'h0F, 3'd2, 1'b1, r, o, lat);
        total++;
        if (r !== 8'h3C || o !== 1'b0 || lat !== 3) begin
            bad++;
            $display("FAIL after_stall: out=%h ovf=%b lat=%0d required 3c 0 3", r, o, lat);
        end
        pop();
    endtask

    task automatic test_idle_out_ready();
        out_ready = 1'b1;
        step(); step();
        out_ready = 1'b0;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out !== 8'h3C) begin
            bad++;
            $display("FAIL idle_out_ready: out_valid=%b in_ready=%b out=%h required 0 1 3c",
                     out_valid, in_ready, out);
        end
    endtask

    task automatic test_async_reset();
        logic [7:0] r; logic o; int lat;
        in = 8'hFF; ctrl = 3'd7; rot = 1'b0; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (out !== 8'h00 || ovf !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL async_reset: out=%h ovf=%b out_valid=%b in_ready=%b required 00 0 0 1",
                     out, ovf, out_valid, in_ready);
        end
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) step();
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL aborted_op: out_valid=%b required 0", out_valid);
        end
        run_op(8'h81, 3'd1, 1'b1, r, o, lat);
        total++;
        if (r !== 8'h03 || o !== 1'b0 || lat !== 3) begin
            bad++;
            $display("FAIL post_reset: out=%h ovf=%b lat=%0d required 03 0 3", r, o, lat);
        end
        pop();
    endtask

    initial begin
        test_reset();
        test_logical();
        test_rotate();
        test_zero_shift();
        test_max_shift();
        test_backpressure();
        test_idle_out_ready();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
